// File: rtl/pattern_pwm_array.sv
// N-channel pattern PWM engine: each channel serialises its own pattern MSB first with
// programmable bit duration, inter-burst gap and burst count; channel 0 also drives a DAC word.
module pattern_pwm_array #(
  parameter int unsigned _NUM_CHANNELS = 4,
  parameter int unsigned _PAT_WIDTH    = 16,
  parameter int unsigned _DAC_WIDTH    = 8,
  parameter int unsigned _CNT_WIDTH    = 16
) (
  input  logic                     sys_clk,
  input  logic                     sys_rst_n,
  input  logic                     cfg_wr,
  input  logic [7:0]               cfg_ch,
  input  logic [7:0]               cfg_duty,
  input  logic [_CNT_WIDTH-1:0]    cfg_dessert,
  input  logic [7:0]               cfg_pulse_num,
  input  logic [_PAT_WIDTH-1:0]    cfg_pat,
  input  logic [_DAC_WIDTH-1:0]    cfg_dac_level,
  input  logic [_NUM_CHANNELS-1:0] start,
  input  logic [_NUM_CHANNELS-1:0] stop,
  output logic [_NUM_CHANNELS-1:0] pwm_out,
  output logic [_NUM_CHANNELS-1:0] busy,
  output logic [_NUM_CHANNELS-1:0] valid,
  output logic                     cfg_err,
  output logic [_DAC_WIDTH-1:0]    dac_data
);

  localparam int unsigned IdxW = $clog2(_PAT_WIDTH);
  localparam logic [IdxW-1:0] IdxMsb = IdxW'(_PAT_WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StPat, StGap} state_e;

  logic [_NUM_CHANNELS-1:0] accept;
  logic [_NUM_CHANNELS-1:0] start_err;
  logic [_DAC_WIDTH-1:0]    dac_level_q, a_dac_q, dac_q;
  logic                     cfg_err_q;

  for (genvar gi = 0; gi < _NUM_CHANNELS; gi++) begin : g_ch
    logic                  wr_sel;
    logic [7:0]            duty_q, a_duty_q;
    logic [_CNT_WIDTH-1:0] dessert_q, a_dessert_q;
    logic [7:0]            pnum_q, a_pnum_q;
    logic [_PAT_WIDTH-1:0] pat_q, a_pat_q, a_pat_d;
    state_e                state_q, state_d;
    logic [IdxW-1:0]       idx_q, idx_d;
    logic [7:0]            dcnt_q, dcnt_d;
    logic [7:0]            bcnt_q, bcnt_d;
    logic [_CNT_WIDTH-1:0] gcnt_q, gcnt_d;
    logic                  pwm_q, pwm_d;
    logic                  valid_q, valid_d;
    logic                  err_d;

    assign wr_sel     = cfg_wr && (cfg_ch == 8'(gi));
    assign accept[gi] = start[gi] && !stop[gi] && (state_q == StIdle) && (duty_q != 8'd0);
    // The active copy is taken from the configuration registers only on an accepted start.
    assign a_pat_d    = accept[gi] ? pat_q : a_pat_q;

    always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      dcnt_d  = dcnt_q;
      bcnt_d  = bcnt_q;
      gcnt_d  = gcnt_q;
      valid_d = 1'b0;
      err_d   = 1'b0;
      if (stop[gi]) begin
        state_d = StIdle;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (accept[gi]) begin
              state_d = StPat;
              idx_d   = IdxMsb;
              dcnt_d  = 8'd0;
              bcnt_d  = 8'd0;
            end else if (start[gi]) begin
              err_d = 1'b1;
            end
          end
          StPat: begin
            if (dcnt_q == a_duty_q - 8'd1) begin
              dcnt_d = 8'd0;
              if (idx_q == '0) begin
                bcnt_d = bcnt_q + 8'd1;
                if ((a_pnum_q != 8'd0) && (bcnt_d == a_pnum_q)) begin
                  state_d = StIdle;
                  valid_d = 1'b1;
                end else if (a_dessert_q == '0) begin
                  idx_d = IdxMsb;
                end else begin
                  state_d = StGap;
                  gcnt_d  = '0;
                end
              end else begin
                idx_d = idx_q - 1'b1;
              end
            end else begin
              dcnt_d = dcnt_q + 8'd1;
            end
          end
          StGap: begin
            if (gcnt_q == a_dessert_q - 1'b1) begin
              state_d = StPat;
              idx_d   = IdxMsb;
              dcnt_d  = 8'd0;
            end else begin
              gcnt_d = gcnt_q + 1'b1;
            end
          end
          default: state_d = StIdle;
        endcase
      end
      pwm_d = (state_d == StPat) ? a_pat_d[idx_d] : 1'b0;
    end

    always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
        duty_q      <= '0;
        dessert_q   <= '0;
        pnum_q      <= '0;
        pat_q       <= '0;
        a_duty_q    <= '0;
        a_dessert_q <= '0;
        a_pnum_q    <= '0;
        a_pat_q     <= '0;
        state_q     <= StIdle;
        idx_q       <= '0;
        dcnt_q      <= '0;
        bcnt_q      <= '0;
        gcnt_q      <= '0;
        pwm_q       <= 1'b0;
        valid_q     <= 1'b0;
      end else begin
        if (wr_sel) begin
          duty_q    <= cfg_duty;
          dessert_q <= cfg_dessert;
          pnum_q    <= cfg_pulse_num;
          pat_q     <= cfg_pat;
        end
        if (accept[gi]) begin
          a_duty_q    <= duty_q;
          a_dessert_q <= dessert_q;
          a_pnum_q    <= pnum_q;
        end
        a_pat_q <= a_pat_d;
        state_q <= state_d;
        idx_q   <= idx_d;
        dcnt_q  <= dcnt_d;
        bcnt_q  <= bcnt_d;
        gcnt_q  <= gcnt_d;
        pwm_q   <= pwm_d;
        valid_q <= valid_d;
      end
    end

    assign pwm_out[gi]   = pwm_q;
    assign busy[gi]      = (state_q != StIdle);
    assign valid[gi]     = valid_q;
    assign start_err[gi] = err_d;
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      dac_level_q <= '0;
      a_dac_q     <= '0;
      dac_q       <= '0;
      cfg_err_q   <= 1'b0;
    end else begin
      if (cfg_wr && (cfg_ch == 8'd0)) begin
        dac_level_q <= cfg_dac_level;
      end
      if (accept[0]) begin
        a_dac_q <= dac_level_q;
      end
      dac_q     <= pwm_out[0] ? a_dac_q : '0;
      cfg_err_q <= (cfg_wr && (cfg_ch >= 8'(_NUM_CHANNELS))) || (|start_err);
    end
  end

  assign dac_data = dac_q;
  assign cfg_err  = cfg_err_q;

endmodule

// File: tb/tb_pattern_pwm_array.sv
// Scoreboard bench for pattern_pwm_array: an arithmetic reference model predicts every
// cycle's outputs, which a separate monitor pops and compares on the falling edge.
module tb_pattern_pwm_array;
  localparam int N = 4;
  localparam int W = 16;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        cfg_wr = 1'b0;
  logic [7:0]  cfg_ch = '0;
  logic [7:0]  cfg_duty = '0;
  logic [15:0] cfg_dessert = '0;
  logic [7:0]  cfg_pulse_num = '0;
  logic [15:0] cfg_pat = '0;
  logic [7:0]  cfg_dac_level = '0;
  logic [3:0]  start = '0;
  logic [3:0]  stop = '0;
  logic [3:0]  pwm_out, busy, valid;
  logic        cfg_err;
  logic [7:0]  dac_data;

  pattern_pwm_array #(
    ._NUM_CHANNELS(N),
    ._PAT_WIDTH   (W),
    ._DAC_WIDTH   (8),
    ._CNT_WIDTH   (16)
  ) dut (
    .sys_clk      (sys_clk),
    .sys_rst_n    (sys_rst_n),
    .cfg_wr       (cfg_wr),
    .cfg_ch       (cfg_ch),
    .cfg_duty     (cfg_duty),
    .cfg_dessert  (cfg_dessert),
    .cfg_pulse_num(cfg_pulse_num),
    .cfg_pat      (cfg_pat),
    .cfg_dac_level(cfg_dac_level),
    .start        (start),
    .stop         (stop),
    .pwm_out      (pwm_out),
    .busy         (busy),
    .valid        (valid),
    .cfg_err      (cfg_err),
    .dac_data     (dac_data)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct packed {
    logic [3:0] pwm;
    logic [3:0] busy;
    logic [3:0] valid;
    logic       err;
    logic [7:0] dac;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state: programmed and active configuration, run flag, elapsed cycles.
  int          m_duty[N], m_des[N], m_pnum[N];
  int          a_duty[N], a_des[N], a_pnum[N];
  logic [15:0] m_pat[N], a_pat[N];
  int          m_k[N];
  bit          m_run[N];
  logic [7:0]  m_dac, m_adac;
  bit          m_pwm0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, req);
    end
  endtask

  always @(negedge sys_clk) begin
    exp_t e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("pwm_out", int'(pwm_out), int'(e.pwm));
      chk("busy", int'(busy), int'(e.busy));
      chk("valid", int'(valid), int'(e.valid));
      chk("cfg_err", int'(cfg_err), int'(e.err));
      chk("dac_data", int'(dac_data), int'(e.dac));
    end
  end

  // Predict the outputs after the coming edge, then advance one cycle and clear strobes.
  task automatic step();
    exp_t e;
    e = '0;
    if (!sys_rst_n) begin
      for (int i = 0; i < N; i++) begin
        m_duty[i] = 0; m_des[i] = 0; m_pnum[i] = 0; m_pat[i] = '0;
        a_duty[i] = 0; a_des[i] = 0; a_pnum[i] = 0; a_pat[i] = '0;
        m_run[i] = 0;  m_k[i] = 0;
      end
      m_dac  = '0;
      m_adac = '0;
    end else begin
      e.dac = m_pwm0 ? m_adac : 8'h00;
      if (cfg_wr && cfg_ch >= 8'(N)) e.err = 1'b1;
      for (int i = 0; i < N; i++) begin
        if (stop[i]) begin
          m_run[i] = 0;
        end else if (m_run[i]) begin
          m_k[i]++;
          if (a_pnum[i] != 0 &&
              m_k[i] == a_pnum[i] * (W * a_duty[i] + a_des[i]) - a_des[i]) begin
            m_run[i]   = 0;
            e.valid[i] = 1'b1;
          end
        end else if (start[i]) begin
          if (m_duty[i] != 0) begin
            a_duty[i] = m_duty[i]; a_des[i] = m_des[i];
            a_pnum[i] = m_pnum[i]; a_pat[i] = m_pat[i];
            if (i == 0) m_adac = m_dac;
            m_run[i] = 1;
            m_k[i]   = 0;
          end else begin
            e.err = 1'b1;
          end
        end
      end
      if (cfg_wr && cfg_ch < 8'(N)) begin
        m_duty[cfg_ch] = int'(cfg_duty);
        m_des[cfg_ch]  = int'(cfg_dessert);
        m_pnum[cfg_ch] = int'(cfg_pulse_num);
        m_pat[cfg_ch]  = cfg_pat;
        if (cfg_ch == 8'd0) m_dac = cfg_dac_level;
      end
      for (int i = 0; i < N; i++) begin
        if (m_run[i]) begin
          int per, pos;
          per       = W * a_duty[i] + a_des[i];
          pos       = m_k[i] % per;
          e.busy[i] = 1'b1;
          if (pos < W * a_duty[i]) e.pwm[i] = a_pat[i][W - 1 - pos / a_duty[i]];
        end
      end
    end
    m_pwm0 = e.pwm[0];
    exp_q.push_back(e);
    @(posedge sys_clk);
    #1;
    cfg_wr = 1'b0;
    start  = '0;
    stop   = '0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic cfg(input int ch, input int duty, input int des, input int pnum,
                     input logic [15:0] pat, input logic [7:0] dac);
    cfg_wr        = 1'b1;
    cfg_ch        = 8'(ch);
    cfg_duty      = 8'(duty);
    cfg_dessert   = 16'(des);
    cfg_pulse_num = 8'(pnum);
    cfg_pat       = pat;
    cfg_dac_level = dac;
    step();
  endtask

  initial begin
    sys_rst_n = 1'b0;
    run(2);
    sys_rst_n = 1'b1;
    run(2);

    // Single burst with DAC level on channel 0.
    cfg(0, 2, 0, 1, 16'hA5A5, 8'hC3);
    start = 4'b0001; step();
    run(40);

    // Repeated single-cycle pulses separated by a gap.
    cfg(1, 1, 5, 3, 16'h8000, 8'h00);
    start = 4'b0010; step();
    run(70);

    // Infinite run, then simultaneous stop and start.
    cfg(2, 3, 4, 0, 16'(($urandom)), 8'h00);
    start = 4'b0100; step();
    run(1000);
    stop = 4'b0100; start = 4'b0100; step();
    run(10);

    // Rejected write and zero-duty start.
    cfg(7, 5, 5, 5, 16'hFFFF, 8'hFF);
    run(2);
    cfg(3, 0, 1, 1, 16'hFFFF, 8'h00);
    start = 4'b1000; step();
    run(3);

    // Shadowed configuration: mid-burst rewrite only affects the next start.
    cfg(0, 2, 0, 1, 16'h1234, 8'h5A);
    start = 4'b0001; step();
    run(10);
    cfg(0, 2, 0, 1, 16'hF00F, 8'hC3);
    run(25);
    start = 4'b0001; step();
    run(40);

    // All channels started together.
    for (int i = 0; i < N; i++) cfg(i, 1 + i % 3, i, 2, 16'($urandom), 8'($urandom));
    start = 4'b1111; step();
    run(120);

    // Reset mid-burst.
    cfg(0, 1, 2, 0, 16'hAAAA, 8'h77);
    start = 4'b0001; step();
    run(7);
    sys_rst_n = 1'b0; step();
    sys_rst_n = 1'b1;
    run(3);

    // Randomised traffic.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 7) == 0) begin
        cfg_wr        = 1'b1;
        cfg_ch        = 8'($urandom_range(0, 5));
        cfg_duty      = ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom_range(1, 3));
        cfg_dessert   = 16'($urandom_range(0, 6));
        cfg_pulse_num = 8'($urandom_range(0, 3));
        cfg_pat       = 16'($urandom);
        cfg_dac_level = 8'($urandom);
      end
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 9) == 0) start[i] = 1'b1;
        if ($urandom_range(0, 59) == 0) stop[i] = 1'b1;
      end
      sys_rst_n = ($urandom_range(0, 499) != 0);
      step();
    end
    sys_rst_n = 1'b1;
    run(2);

    @(negedge sys_clk);
    #1;
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
